// File: rtl/signal_lamp_pkg.sv
// Shared mode encodings and default timing parameters for the signal lamp driver.
package signal_lamp_pkg;

  typedef enum logic [1:0] {
    ModeRun   = 2'b00,
    ModeFlash = 2'b01,
    ModeFault = 2'b10
  } mode_e;

  localparam int unsigned TickDivDefault    = 1000;
  localparam int unsigned IdleTicksDefault  = 4;
  localparam int unsigned BlinkTicksDefault = 5;

endpackage

// File: rtl/signal_lamp_if.sv
// Lamp command inputs and physical lamp / status outputs of the lamp driver.
interface signal_lamp_if;
  logic       red_in;
  logic       yellow_in;
  logic       green_in;
  logic       fault_clr;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       fault;
  logic [1:0] mode;

  // Upstream side: drives lamp commands, observes lamp drives.
  modport master (
    output red_in, yellow_in, green_in, fault_clr,
    input  lamp_red, lamp_yellow, lamp_green, fault, mode
  );

  // Driver side.
  modport slave (
    input  red_in, yellow_in, green_in, fault_clr,
    output lamp_red, lamp_yellow, lamp_green, fault, mode
  );
endinterface

// File: rtl/signal_lamp_driver_tick_prescaler.sv
// Free-running prescaler: one-cycle tick every DIV clk cycles.
module tick_prescaler
  import signal_lamp_pkg::*;
#(
  parameter int unsigned DIV = TickDivDefault
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick while the count sits at its last value; wrap to zero on that edge.
  always_comb begin
    tick  = (cnt_q == CntLast);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/signal_lamp_driver.sv
// Lamp driver: mirrors upstream lamp commands, falls back to flashing yellow
// when the upstream goes dark, and latches a red-only fault on conflicting commands.
module signal_lamp_driver
  import signal_lamp_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TickDivDefault,
  parameter int unsigned IDLE_TICKS  = IdleTicksDefault,
  parameter int unsigned BLINK_TICKS = BlinkTicksDefault
) (
  input logic          clk,
  input logic          rst_n,
  signal_lamp_if.slave bus
);
  localparam int unsigned IdleW  = $clog2(IDLE_TICKS + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_TICKS + 1);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_TICKS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

  logic              tick;
  mode_e             state_q, state_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              red_q, red_d, yel_q, yel_d, grn_q, grn_d, fault_q, fault_d;
  logic              illegal, dark, flash_yel;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign illegal = (bus.red_in & bus.yellow_in) | (bus.red_in & bus.green_in) |
                   (bus.yellow_in & bus.green_in);
  assign dark    = ~(bus.red_in | bus.yellow_in | bus.green_in);

  // Next-state, counters, then lamp drives decoded from the state being entered.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    blink_d   = blink_q;
    flash_yel = yel_q;
    case (state_q)
      ModeRun: begin
        if (illegal) begin
          state_d = ModeFault;
        end else if (!dark) begin
          idle_d = '0;
        end else if (tick) begin
          if (idle_q >= IdleLast) begin
            state_d   = ModeFlash;
            idle_d    = '0;
            blink_d   = '0;
            flash_yel = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ModeFlash: begin
        if (illegal) begin
          state_d = ModeFault;
        end else if (!dark) begin
          state_d = ModeRun;
          idle_d  = '0;
        end else if (tick) begin
          if (blink_q >= BlinkLast) begin
            blink_d   = '0;
            flash_yel = ~yel_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
      end
      ModeFault: begin
        if (bus.fault_clr && !illegal) begin
          state_d = ModeRun;
          // RUN keeps the idle counter, so a coinciding dark tick is counted.
          idle_d  = (dark && tick) ? IdleW'(1) : '0;
        end
      end
      default: begin
        state_d = ModeRun;
        idle_d  = '0;
      end
    endcase

    red_d   = 1'b0;
    yel_d   = 1'b0;
    grn_d   = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ModeFlash: yel_d = flash_yel;
      ModeFault: begin
        red_d   = 1'b1;
        fault_d = 1'b1;
      end
      default: begin
        red_d = bus.red_in;
        yel_d = bus.yellow_in;
        grn_d = bus.green_in;
      end
    endcase
  end

  // State, counters and registered lamp drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ModeRun;
      idle_q  <= '0;
      blink_q <= '0;
      red_q   <= 1'b0;
      yel_q   <= 1'b0;
      grn_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      blink_q <= blink_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
      fault_q <= fault_d;
    end
  end

  assign bus.lamp_red    = red_q;
  assign bus.lamp_yellow = yel_q;
  assign bus.lamp_green  = grn_q;
  assign bus.fault       = fault_q;
  assign bus.mode        = state_q;
endmodule

// File: tb/tb_signal_lamp_driver.sv
// Bench for signal_lamp_driver: vector table, hand sequences, random vs. reference model.
module tb_signal_lamp_driver;
  import signal_lamp_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned IT = 2;
  localparam int unsigned BT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  signal_lamp_if bus ();

  signal_lamp_driver #(
    .TICK_DIV    (TD),
    .IDLE_TICKS  (IT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 RUN, 1 FLASH, 2 FAULT.
  int   m_mode, m_presc, m_dark_ticks, m_flash_ticks;
  logic m_r, m_y, m_g;

  typedef struct {
    logic       r, y, g, c;
    logic [5:0] exp; // {mode, fault, lamp_red, lamp_yellow, lamp_green}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] obs();
    return {bus.mode, bus.fault, bus.lamp_red, bus.lamp_yellow, bus.lamp_green};
  endfunction

  function automatic logic [5:0] model_out();
    logic yel;
    case (m_mode)
      0: return {2'b00, 1'b0, m_r, m_y, m_g};
      1: begin
        yel = ((m_flash_ticks / BT) % 2) == 0;
        return {2'b01, 1'b0, 1'b0, yel, 1'b0};
      end
      default: return {2'b10, 1'b1, 3'b100};
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_presc = 0; m_dark_ticks = 0; m_flash_ticks = 0;
    m_r = 1'b0; m_y = 1'b0; m_g = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic y, input logic g, input logic c);
    int  n;
    bit  tick, illegal, dark;
    n       = int'(r) + int'(y) + int'(g);
    illegal = (n >= 2);
    dark    = (n == 0);
    tick    = (m_presc == TD - 1);
    case (m_mode)
      0: begin
        if (illegal) m_mode = 2;
        else if (!dark) m_dark_ticks = 0;
        else if (tick) begin
          m_dark_ticks++;
          if (m_dark_ticks >= IT) begin
            m_mode = 1;
            m_flash_ticks = 0;
          end
        end
      end
      1: begin
        if (illegal) m_mode = 2;
        else if (!dark) begin
          m_mode = 0;
          m_dark_ticks = 0;
        end else if (tick) m_flash_ticks++;
      end
      default: begin
        if (c && !illegal) begin
          m_mode = 0;
          m_dark_ticks = (dark && tick) ? 1 : 0;
        end
      end
    endcase
    m_r = r; m_y = y; m_g = g;
    m_presc = (m_presc + 1) % TD;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {mode,fault,r,y,g}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic r, input logic y, input logic g, input logic c);
    bus.red_in = r; bus.yellow_in = y; bus.green_in = g; bus.fault_clr = c;
    @(posedge clk);
    model_step(r, y, g, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.red_in = 1'b0; bus.yellow_in = 1'b0; bus.green_in = 1'b0; bus.fault_clr = 1'b0;
    rst_n = 1'b0;
    #1 chk("reset_state", obs(), 6'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic r, input logic y, input logic g, input logic c,
                     input logic [5:0] exp);
    vec_t v;
    v.r = r; v.y = y; v.g = g; v.c = c; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    bus.red_in = 1'b0; bus.yellow_in = 1'b0; bus.green_in = 1'b0; bus.fault_clr = 1'b0;
    model_reset();

    // Dark after reset: FLASH at cycle 8, yellow 12 on / 12 off, then red exits.
    do_reset();
    for (int cyc = 1; cyc <= 31; cyc++) begin
      logic [5:0] e;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = {(cyc >= 8) ? 2'b01 : 2'b00, 1'b0, 1'b0, (cyc >= 8 && cyc < 20), 1'b0};
      chk("idle_flash_blink", obs(), e);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("flash_exit_red", obs(), 6'b00_0_100);

    // Vector table: mirroring, fault entry/exit, fault_clr priorities.
    for (int i = 0; i < 20; i++) begin
      case (i / 5)
        1:       add(1'b0, 1'b1, 1'b0, 1'b0, 6'b00_0_010);
        2:       add(1'b0, 1'b0, 1'b1, 1'b0, 6'b00_0_001);
        default: add(1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_100);
      endcase
    end
    add(1'b1, 1'b0, 1'b1, 1'b0, 6'b10_1_100); // illegal -> FAULT
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b10_1_100); // latched
    add(1'b0, 1'b1, 1'b1, 1'b1, 6'b10_1_100); // clr with illegal inputs
    add(1'b1, 1'b0, 1'b1, 1'b1, 6'b10_1_100); // illegal beats clr
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b10_1_100); // no clr, stays
    add(1'b1, 1'b0, 1'b0, 1'b1, 6'b00_0_100); // clr + legal red
    add(1'b0, 1'b0, 1'b1, 1'b1, 6'b00_0_001); // clr ignored in RUN
    add(1'b1, 1'b1, 1'b1, 1'b0, 6'b10_1_100); // all three -> FAULT
    add(1'b0, 1'b0, 1'b0, 1'b1, 6'b00_0_000); // clr with dark is legal
    add(1'b0, 1'b0, 1'b1, 1'b0, 6'b00_0_001);
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].c);
      chk($sformatf("table_row_%0d", i), obs(), tbl[i].exp);
    end

    // Asynchronous reset in FAULT, then FLASH again at cycle 8.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("enter_fault", obs(), 6'b10_1_100);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("fault_held", obs(), 6'b10_1_100);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_fault", obs(), 6'b00_0_000);
    model_reset();
    @(negedge clk);
    bus.fault_clr = 1'b0;
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (cyc == 7) chk("post_reset_run_c7", obs(), 6'b00_0_000);
      if (cyc == 8) chk("post_reset_flash_c8", obs(), 6'b01_0_010);
    end

    // Randomized bursts checked against the reference model.
    do_reset();
    for (int n = 0; n < 3000; ) begin
      logic [2:0] pat;
      int         sel, len;
      sel = $urandom_range(0, 9);
      case (sel)
        5:       pat = 3'b100;
        6:       pat = 3'b010;
        7:       pat = 3'b001;
        8, 9:    pat = 3'($urandom_range(0, 7));
        default: pat = 3'b000;
      endcase
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        logic c;
        c = ($urandom_range(0, 3) == 0);
        cycle(pat[2], pat[1], pat[0], c);
        chk("random_vs_model", obs(), model_out());
        n++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
